// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and helpers used by the arbiter, reservation stations and ROB.
`ifndef CDB_DEPTH
`define CDB_DEPTH 2
`endif

package cdb_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;

  typedef logic [DATA_W-1:0] procyon_data_t;
  typedef logic [TAG_W-1:0]  procyon_tag_t;

  // One broadcast bus as seen by every tag-match consumer.
  typedef struct packed {
    logic          en;
    procyon_data_t data;
    procyon_tag_t  tag;
  } cdb_bus_t;

  // Index increment with wrap at n; n need not be a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_multi_picker.sv
// Combinational round-robin picker granting up to CDB_DEPTH requesters,
// scanning from i_rr_ptr upward with wrap. The j-th grant in scan order
// is assigned to bus j.
module cdb_arbiter_rr_multi_picker #(
  parameter int NUM_FU    = 4,
  parameter int CDB_DEPTH = 2,
  localparam int IDXW     = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]    i_req,
  input  logic [IDXW-1:0]      i_rr_ptr,
  output logic [NUM_FU-1:0]    o_grant,
  output logic [CDB_DEPTH-1:0] o_bus_valid,
  output logic [IDXW-1:0]      o_bus_idx [0:CDB_DEPTH-1],
  output logic [IDXW-1:0]      o_last_idx
);

  // Walk the FUs in priority order and hand out busses until they run out.
  always_comb begin
    int cnt;
    int pos;
    o_grant     = '0;
    o_bus_valid = '0;
    for (int j = 0; j < CDB_DEPTH; j++) o_bus_idx[j] = '0;
    o_last_idx  = i_rr_ptr;
    cnt         = 0;
    pos         = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      pos = int'(i_rr_ptr) + k;
      if (pos >= NUM_FU) pos = pos - NUM_FU;
      for (int i = 0; i < NUM_FU; i++) begin
        if (i == pos && i_req[i] && cnt < CDB_DEPTH) begin
          o_grant[i] = 1'b1;
          for (int j = 0; j < CDB_DEPTH; j++) begin
            if (j == cnt) begin
              o_bus_valid[j] = 1'b1;
              o_bus_idx[j]   = IDXW'(i);
            end
          end
          o_last_idx = IDXW'(i);
          cnt        = cnt + 1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per FU, round-robin grant
// of up to CDB_DEPTH holds per cycle, stall back to FUs that lost.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = 4,
  parameter int CDB_DEPTH = `CDB_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_fu_valid [0:NUM_FU-1],
  input  procyon_data_t i_fu_data  [0:NUM_FU-1],
  input  procyon_tag_t  i_fu_tag   [0:NUM_FU-1],
  output logic          o_fu_stall [0:NUM_FU-1],
  output logic          o_cdb_en   [0:CDB_DEPTH-1],
  output procyon_data_t o_cdb_data [0:CDB_DEPTH-1],
  output procyon_tag_t  o_cdb_tag  [0:CDB_DEPTH-1]
);

  localparam int IDXW = $clog2(NUM_FU);

  logic [NUM_FU-1:0]    r_hold_valid;
  procyon_data_t        r_hold_data [0:NUM_FU-1];
  procyon_tag_t         r_hold_tag  [0:NUM_FU-1];
  logic [IDXW-1:0]      r_rr_ptr;

  logic [NUM_FU-1:0]    w_grant;
  logic [CDB_DEPTH-1:0] w_bus_valid;
  logic [IDXW-1:0]      w_bus_idx [0:CDB_DEPTH-1];
  logic [IDXW-1:0]      w_last_idx;
  logic [NUM_FU-1:0]    w_stall;
  cdb_bus_t             w_bus [0:CDB_DEPTH-1];

  cdb_arbiter_rr_multi_picker #(
    .NUM_FU    (NUM_FU),
    .CDB_DEPTH (CDB_DEPTH)
  ) u_picker (
    .i_req       (r_hold_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_bus_valid (w_bus_valid),
    .o_bus_idx   (w_bus_idx),
    .o_last_idx  (w_last_idx)
  );

  // Route granted holds onto their busses; a flush silences every bus.
  always_comb begin
    for (int k = 0; k < CDB_DEPTH; k++) begin
      w_bus[k].en   = w_bus_valid[k] & ~i_flush;
      w_bus[k].data = r_hold_data[w_bus_idx[k]];
      w_bus[k].tag  = r_hold_tag[w_bus_idx[k]];
      o_cdb_en[k]   = w_bus[k].en;
      o_cdb_data[k] = w_bus[k].data;
      o_cdb_tag[k]  = w_bus[k].tag;
    end
  end

  // An FU stalls when its hold is occupied and did not win a bus.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      w_stall[i]    = r_hold_valid[i] & ~w_grant[i] & ~i_flush;
      o_fu_stall[i] = w_stall[i];
    end
  end

  // Hold occupancy: flush clears, unstalled holds reload from the FU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (i_flush)          r_hold_valid[i] <= 1'b0;
        else if (!w_stall[i]) r_hold_valid[i] <= i_fu_valid[i];
      end
    end
  end

  // Hold payload is only captured alongside a valid load; not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (!i_flush && !w_stall[i] && i_fu_valid[i]) begin
        r_hold_data[i] <= i_fu_data[i];
        r_hold_tag[i]  <= i_fu_tag[i];
      end
    end
  end

  // Priority pointer moves just past the last FU granted this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (|w_grant && !i_flush) begin
      r_rr_ptr <= IDXW'(wrap_inc(32'(w_last_idx), NUM_FU));
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the `CDB_DEPTH common data busses among NUM_FU functional units.
- Each FU result lands in a one-entry per-FU holding register.
- Each cycle, a round-robin picker grants up to CDB_DEPTH held results onto the busses.
- FUs that are not granted are stalled. The busses feed every reservation station's tag-match/wakeup logic and the reorder buffer.

Parameters:
- NUM_FU, 4: number of requesting functional units; must be at least 2.
- CDB_DEPTH, `CDB_DEPTH (2): number of CDB busses driven; must be at least 1 and no greater than NUM_FU.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_flush  in  1  pipeline flush; drops all held and incoming results.
- i_fu_valid  in  [0:NUM_FU-1] x 1  FU result valid.
- i_fu_data  in  [0:NUM_FU-1] x procyon_data_t  FU result data.
- i_fu_tag  in  [0:NUM_FU-1] x procyon_tag_t  FU destination tag.
- o_fu_stall  out  [0:NUM_FU-1] x 1  FU must hold its result; this is the FU's i_fu_stall.
- o_cdb_en  out  [0:CDB_DEPTH-1] x 1  bus k carries a valid broadcast.
- o_cdb_data  out  [0:CDB_DEPTH-1] x procyon_data_t  broadcast data.
- o_cdb_tag  out  [0:CDB_DEPTH-1] x procyon_tag_t  broadcast tag.

Behaviour:
- State:
  - hold_valid/hold_data/hold_tag per FU.
  - rr_ptr, width $clog2(NUM_FU): the highest-priority FU.
- Reset (asynchronous, immediate):
  - hold_valid all 0 and rr_ptr = 0.
  - Therefore o_cdb_en all 0 and o_fu_stall all 0.
  - Data/tag registers are not reset; outputs are don't-care while en = 0.
- Request vector: req = hold_valid.
- Grant, combinational:
  - Scan FUs in order rr_ptr, rr_ptr+1, ... (mod NUM_FU).
  - The first CDB_DEPTH requesters found are granted.
  - The j-th granted FU in scan order drives bus j.
  - Unused busses have o_cdb_en = 0.
  - Latency: an FU result presented in cycle N is broadcast no earlier than cycle N+1.
  - o_cdb_* are combinational from the hold registers and the grant. There is no further register stage.
- Stall: o_fu_stall[i] = hold_valid[i] & ~grant[i], combinational, same cycle.
- Hold update per FU, priority in this order:
  - i_flush: hold_valid <= 0. i_fu_valid is ignored.
  - ~o_fu_stall[i]: hold_valid <= i_fu_valid[i], and data/tag are captured when valid. This covers "grant and refill" in one cycle, giving full throughput.
  - stalled: hold unchanged; the FU keeps its result steady.
- rr_ptr update:
  - If any grant and ~i_flush: rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
  - Otherwise rr_ptr is unchanged.
  - Wrap-around is modulo NUM_FU; NUM_FU need not be a power of 2.
- Flush cycle:
  - o_cdb_en forced to all 0 and o_fu_stall forced to all 0.
  - The cycle after a flush has no broadcasts.
- Simultaneous events:
  - Fewer requesters than busses: all are granted and there are no stalls.
  - A granted FU with a new valid result is accepted in the same cycle.
- Invariants:
  - No FU is granted on two busses.
  - Tags on enabled busses come from distinct holds.
  - No result is lost or duplicated absent flush.
  - Starvation bound: a held result is broadcast within ceil(NUM_FU/CDB_DEPTH) cycles.

Decomposition:
- procyon_types package: add a cdb_bus_t struct (en, data, tag) for reuse by the reservation stations and the ROB. procyon_data_t and procyon_tag_t already live there.
- One natural sub-module: rr_multi_picker. It is combinational, takes req and rr_ptr, and produces a one-hot grant vector, a per-bus FU index, and last_idx. It is parameterised by NUM_FU and CDB_DEPTH.
- Hold registers and rr_ptr stay in cdb_arbiter.

Test Plan (NUM_FU=4, CDB_DEPTH=2 unless noted):
1. Reset, then FU1 valid tag=5 data=0xAA in cycle 0 -> cycle 1: en={1,0}, bus0 tag=5 data=0xAA; no stalls; rr_ptr=2 in cycle 2.
2. All four FUs valid in cycle 0 (tags 10..13), rr_ptr=0:
   - cycle 1: bus0=tag10, bus1=tag11; o_fu_stall={0,0,1,1}.
   - cycle 2: bus0=tag12, bus1=tag13; rr_ptr returns to 0.
3. All four FUs continuously valid for 6 cycles -> grants alternate {0,1},{2,3},{0,1}...; each FU stalls every other cycle; every tag appears exactly once on the CDB, none lost.
4. FU2 valid on cycles 0-3 with tags 1-4, others idle -> bus0 shows tags 1-4 on cycles 1-4; o_fu_stall[2] never asserts.
5. Holds of FUs 0-3 full, i_flush in cycle N with FU0 presenting tag=7 -> cycle N: en all 0, stalls all 0; cycle N+1: en all 0; tag 7 never broadcast.
6. rst asserted asynchronously mid-cycle while two holds are valid -> o_cdb_en drops to 0 before the next clk edge; after release, rr_ptr=0 and a fresh FU3 result broadcasts on bus0 one cycle later.
